// File: rtl/div_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// div_share_arbiter_if
//
// Purpose: bundles every non-clock signal of the shared-divider arbiter. This
// covers the two requester channels, the response channel and the link to the
// external radix-2 divider.
//
// Signals (directions as seen by the arbiter, i.e. the slave modport):
//   req_valid[1:0]  in   request from requester i
//   req_ready[1:0]  out  one-hot accept pulse (IDLE only)
//   dividend0/1     in   WIDTH dividend of requester 0/1
//   divisor0/1      in   WIDTH divisor of requester 0/1
//   rsp_valid       out  result available, held until rsp_ready
//   rsp_ready       in   consumer accepts the result
//   rsp_id          out  requester owning the result
//   rsp_q / rsp_r   out  WIDTH quotient / remainder
//   rsp_dbz         out  divisor was zero
//   rsp_err         out  watchdog expired, q/r invalid
//   div_start       out  one-cycle divider start pulse
//   div_dividend    out  WIDTH latched dividend for the divider
//   div_divisor     out  WIDTH latched divisor for the divider
//   div_q / div_r   in   WIDTH divider quotient / corrected remainder
//   div_busy        in   divider busy flag
//
// Modports: slave = arbiter side, master = environment (requesters,
// consumer and divider) side.
// ---------------------------------------------------------------------------
interface div_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] dividend0;
    logic [WIDTH-1:0] dividend1;
    logic [WIDTH-1:0] divisor0;
    logic [WIDTH-1:0] divisor1;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_q;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_dbz;
    logic             rsp_err;

    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             div_busy;

    modport slave (
        input  req_valid, dividend0, dividend1, divisor0, divisor1,
        input  rsp_ready,
        input  div_q, div_r, div_busy,
        output req_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
        output div_start, div_dividend, div_divisor
    );

    modport master (
        output req_valid, dividend0, dividend1, divisor0, divisor1,
        output rsp_ready,
        output div_q, div_r, div_busy,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
        input  div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_arbiter.sv
// ---------------------------------------------------------------------------
// div_share_arbiter
//
// Purpose: shares one external 32-bit unsigned start/busy divider between two
// requesters. Requests are granted round-robin. The winner's operands are
// latched and a start pulse is sent to the divider. The arbiter follows the
// divider's busy rise and fall, captures q/r and returns them tagged with the
// winner's id. A zero divisor is answered locally without starting the
// divider. A watchdog turns a hung divider into an error response.
//
// Parameters:
//   WIDTH    operand/result width, must match the divider
//   TIMEOUT  max cycles spent waiting for busy plus running before error
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous, active-high (shared with the divider)
//   bus     div_share_arbiter_if.slave, request/response/divider signals
// ---------------------------------------------------------------------------
module div_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input logic                clock,
    input logic                reset,
    div_share_arbiter_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam int                WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic              rr_ptr;
    logic [WDOG_W-1:0] wdog;

    logic              grant_any;
    logic              grant_id;
    logic [WIDTH-1:0]  sel_dividend;
    logic [WIDTH-1:0]  sel_divisor;

    logic              in_watch;
    logic              div_done;
    logic              wdog_expired;

    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [WIDTH-1:0]  rsp_q_reg;
    logic [WIDTH-1:0]  rsp_r_reg;
    logic              rsp_dbz_reg;
    logic              rsp_err_reg;
    logic              div_start_reg;
    logic [WIDTH-1:0]  div_dividend_reg;
    logic [WIDTH-1:0]  div_divisor_reg;

    // Grant selection. rr_ptr names the requester that wins a tie; a lone
    // requester wins regardless. Grants only exist while idle.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == S_IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = rr_ptr;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = 1'b0;
                end
            endcase
        end
    end

    assign sel_dividend = grant_id ? bus.dividend1 : bus.dividend0;
    assign sel_divisor  = grant_id ? bus.divisor1  : bus.divisor0;

    // The state is forced idle during reset, so gate the accept pulse here to
    // keep req_ready low while reset is held.
    assign bus.req_ready = (grant_any && !reset) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // The watchdog only runs while the divider owns the transaction.
    assign in_watch     = (state == S_WAIT_BUSY) || (state == S_RUN);
    assign div_done     = (state == S_RUN) && !bus.div_busy;
    assign wdog_expired = in_watch && (wdog == WDOG_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            rr_ptr           <= 1'b0;
            wdog             <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= 1'b0;
            rsp_q_reg        <= '0;
            rsp_r_reg        <= '0;
            rsp_dbz_reg      <= 1'b0;
            rsp_err_reg      <= 1'b0;
            div_start_reg    <= 1'b0;
            div_dividend_reg <= '0;
            div_divisor_reg  <= '0;
        end else begin
            div_start_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        rr_ptr           <= ~grant_id;
                        rsp_id_reg       <= grant_id;
                        div_dividend_reg <= sel_dividend;
                        div_divisor_reg  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            // A zero divisor is answered here and the
                            // divider is never started.
                            rsp_q_reg     <= '1;
                            rsp_r_reg     <= sel_dividend;
                            rsp_dbz_reg   <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            // Start is registered so that it is high for
                            // exactly the ISSUE cycle.
                            div_start_reg <= 1'b1;
                            state         <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY, S_RUN: begin
                    // A real completion takes priority over a watchdog
                    // expiry that falls in the same cycle.
                    if (div_done) begin
                        rsp_q_reg     <= bus.div_q;
                        rsp_r_reg     <= bus.div_r;
                        rsp_valid_reg <= 1'b1;
                        state         <= S_RESP;
                    end else if (wdog_expired) begin
                        rsp_q_reg     <= '0;
                        rsp_r_reg     <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                        if ((state == S_WAIT_BUSY) && bus.div_busy) begin
                            state <= S_RUN;
                        end
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_dbz_reg   <= 1'b0;
                        rsp_err_reg   <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_id       = rsp_id_reg;
    assign bus.rsp_q        = rsp_q_reg;
    assign bus.rsp_r        = rsp_r_reg;
    assign bus.rsp_dbz      = rsp_dbz_reg;
    assign bus.rsp_err      = rsp_err_reg;
    assign bus.div_start    = div_start_reg;
    assign bus.div_dividend = div_dividend_reg;
    assign bus.div_divisor  = div_divisor_reg;

    // Protocol invariants of the arbiter itself.
    a_ready_onehot: assert property (
        @(posedge clock) disable iff (reset) $onehot0(bus.req_ready)
    );

    a_start_not_busy: assert property (
        @(posedge clock) disable iff (reset) div_start_reg |-> !bus.div_busy
    );

    // Operands may only change on the IDLE -> ISSUE/RESP transition.
    a_operands_stable: assert property (
        @(posedge clock) disable iff (reset)
        ((state != S_IDLE) && ($past(state) != S_IDLE))
            |-> ($stable(div_dividend_reg) && $stable(div_divisor_reg))
    );

endmodule

// File: tb/tb_div_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_share_arbiter
//
// Purpose: self-checking bench for div_share_arbiter. It contains a
// behavioural start/busy divider (busy for 32 cycles, or forever in hang
// mode), a table of directed vectors, hand-written multi-cycle sequences and a
// randomized run checked against a requester-level reference model.
// ---------------------------------------------------------------------------
module tb_div_share_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset;
    logic hang_mode;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    div_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    div_share_arbiter #(
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural divider: busy rises the cycle after start, stays high for
    // 32 cycles, then drops with q/r valid. In hang mode busy never drops.
    logic             mdl_busy;
    logic [WIDTH-1:0] mdl_q;
    logic [WIDTH-1:0] mdl_r;
    int               mdl_left;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mdl_busy <= 1'b0;
            mdl_q    <= '0;
            mdl_r    <= '0;
            mdl_left <= 0;
        end else if (bus.div_start) begin
            mdl_busy <= 1'b1;
            mdl_left <= 31;
        end else if (mdl_busy && !hang_mode) begin
            if (mdl_left == 0) begin
                mdl_busy <= 1'b0;
                mdl_q    <= (bus.div_divisor == '0) ? '1 : bus.div_dividend / bus.div_divisor;
                mdl_r    <= (bus.div_divisor == '0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
            end else begin
                mdl_left <= mdl_left - 1;
            end
        end
    end

    assign bus.div_busy = mdl_busy;
    assign bus.div_q    = mdl_q;
    assign bus.div_r    = mdl_r;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        exp_id;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [31:0] a1, input logic [31:0] b1);
        bus.req_valid = valid;
        bus.dividend0 = a0;
        bus.divisor0  = b0;
        bus.dividend1 = a1;
        bus.divisor1  = b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"},    32'(bus.req_ready),  32'd0);
        checkOutput({tag, "_rsp_valid"},    32'(bus.rsp_valid),  32'd0);
        checkOutput({tag, "_rsp_id"},       32'(bus.rsp_id),     32'd0);
        checkOutput({tag, "_rsp_q"},        bus.rsp_q,           32'd0);
        checkOutput({tag, "_rsp_r"},        bus.rsp_r,           32'd0);
        checkOutput({tag, "_rsp_dbz"},      32'(bus.rsp_dbz),    32'd0);
        checkOutput({tag, "_rsp_err"},      32'(bus.rsp_err),    32'd0);
        checkOutput({tag, "_div_start"},    32'(bus.div_start),  32'd0);
        checkOutput({tag, "_div_dividend"}, bus.div_dividend,    32'd0);
        checkOutput({tag, "_div_divisor"},  bus.div_divisor,     32'd0);
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One request from IDLE to handshake, called at a negedge. Cycle 0 is the
    // accept cycle; n counts the following cycles at their negedge.
    task automatic runAndCheck(input string tag, input logic [1:0] valid, input logic [1:0] keep,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic exp_id, input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_dbz, input logic exp_err, input int stall,
                               output int acc_cyc);
        int n;
        int start_at;
        int rsp_at;
        int exp_start;
        int exp_rsp;
        exp_start = exp_dbz ? -1 : 1;
        exp_rsp   = exp_dbz ? 1 : (exp_err ? TIMEOUT + 2 : 35);
        applyStimulus(valid, a0, b0, a1, b1);
        bus.rsp_ready = (stall == 0);
        #1;
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), exp_id ? 32'd2 : 32'd1);
        @(posedge clock);
        #1 acc_cyc = cyc;
        @(negedge clock);
        applyStimulus(valid & keep, a0, b0, a1, b1);
        start_at = -1;
        rsp_at   = -1;
        for (n = 1; n <= TIMEOUT + 10; n++) begin
            if (bus.div_start && (start_at < 0)) start_at = n;
            if (bus.rsp_valid) begin
                rsp_at = n;
                break;
            end
            @(negedge clock);
        end
        checkOutput({tag, "_start_cycle"}, 32'(start_at), 32'(exp_start));
        checkOutput({tag, "_rsp_cycle"},   32'(rsp_at),   32'(exp_rsp));
        checkOutput({tag, "_rsp_id"},      32'(bus.rsp_id),  32'(exp_id));
        checkOutput({tag, "_rsp_q"},       bus.rsp_q,        exp_q);
        checkOutput({tag, "_rsp_r"},       bus.rsp_r,        exp_r);
        checkOutput({tag, "_rsp_dbz"},     32'(bus.rsp_dbz), 32'(exp_dbz));
        checkOutput({tag, "_rsp_err"},     32'(bus.rsp_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            checkOutput({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            checkOutput({tag, "_hold_q"},     bus.rsp_q,          exp_q);
            checkOutput({tag, "_hold_r"},     bus.rsp_r,          exp_r);
            checkOutput({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] randDivisor();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1, 2:    return 32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    // Start/busy overlap is illegal whenever the arbiter issues a start.
    always @(negedge clock) begin
        if (!reset && bus.div_start) checkOutput("start_vs_busy", 32'(mdl_busy), 32'd0);
    end

    initial begin
        vec_t        vecs[10];
        int          acc;
        int          prev_acc;
        logic        seen;
        logic [1:0]  pend;
        logic [1:0]  keep;
        logic [31:0] pa[2];
        logic [31:0] pb[2];
        logic        pref;
        logic        win;
        logic [31:0] ea;
        logic [31:0] eb;

        vecs[0] = '{2'b01, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{2'b10, 32'd0, 32'd0, 32'd1234, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1234, 1'b1};
        vecs[2] = '{2'b11, 32'd50, 32'd5, 32'hFFFFFFFF, 32'd16, 1'b0, 32'd10, 32'd0, 1'b0};
        vecs[3] = '{2'b11, 32'd50, 32'd5, 32'hFFFFFFFF, 32'd16, 1'b1, 32'h0FFFFFFF, 32'd15, 1'b0};
        vecs[4] = '{2'b10, 32'd0, 32'd0, 32'd7, 32'd9, 1'b1, 32'd0, 32'd7, 1'b0};
        vecs[5] = '{2'b11, 32'd0, 32'd3, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0};
        vecs[6] = '{2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[7] = '{2'b11, 32'd9, 32'd0, 32'd1000000, 32'd999, 1'b1, 32'd1001, 32'd1, 1'b0};
        vecs[8] = '{2'b11, 32'd9, 32'd0, 32'd1000000, 32'd999, 1'b0, 32'hFFFFFFFF, 32'd9, 1'b1};
        vecs[9] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 32'd0, 32'h80000000, 1'b0};

        hang_mode = 1'b0;
        reset = 1'b1;
        applyStimulus(2'b11, 32'd10, 32'd3, 32'd20, 32'd4);
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        checkAllZero("por");
        reset = 1'b0;
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);

        $display("[TB] directed vector table");
        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].valid, 2'b00, vecs[i].a0, vecs[i].b0,
                        vecs[i].a1, vecs[i].b1, vecs[i].exp_id, vecs[i].exp_q, vecs[i].exp_r,
                        vecs[i].exp_dbz, 1'b0, 0, acc);
        end

        $display("[TB] both requesters held, alternating service");
        resetDut();
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            runAndCheck($sformatf("held%0d", k), 2'b11, 2'b11, 32'd50, 32'd5, 32'hFFFFFFFF, 32'd16,
                        k[0], k[0] ? 32'h0FFFFFFF : 32'd10, k[0] ? 32'd15 : 32'd0,
                        1'b0, 1'b0, 0, acc);
            if (k > 0) checkOutput($sformatf("held_gap%0d", k), 32'(acc - prev_acc), 32'd36);
            prev_acc = acc;
        end
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("[TB] response stalled for 10 cycles");
        resetDut();
        runAndCheck("stall", 2'b11, 2'b11, 32'd200, 32'd9, 32'd300, 32'd7,
                    1'b0, 32'd22, 32'd2, 1'b0, 1'b0, 10, acc);
        #1;
        checkOutput("stall_next_grant", 32'(bus.req_ready), 32'd2);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);

        $display("[TB] hung divider watchdog");
        resetDut();
        hang_mode = 1'b1;
        runAndCheck("hang", 2'b10, 2'b00, 32'd0, 32'd0, 32'd77, 32'd3,
                    1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 0, acc);
        applyStimulus(2'b01, 32'd5, 32'd1, 32'd0, 32'd0);
        #1;
        checkOutput("hang_back_idle", 32'(bus.req_ready), 32'd1);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        hang_mode = 1'b0;
        resetDut();

        $display("[TB] reset in the middle of a division");
        applyStimulus(2'b01, 32'd1000, 32'd3, 32'd0, 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (19) @(negedge clock);
        checkOutput("mid_busy",     32'(mdl_busy),    32'd1);
        checkOutput("mid_dividend", bus.div_dividend, 32'd1000);
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checkOutput("no_rsp_after_reset", 32'(seen), 32'd0);
        runAndCheck("after_reset", 2'b01, 2'b00, 32'd1000, 32'd7, 32'd0, 32'd0,
                    1'b0, 32'd142, 32'd6, 1'b0, 1'b0, 0, acc);

        $display("[TB] randomized traffic against reference model");
        resetDut();
        pend = 2'b00;
        pref = 1'b0;
        pa[0] = 32'd0; pa[1] = 32'd0;
        pb[0] = 32'd0; pb[1] = 32'd0;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    pa[i]   = $urandom();
                    pb[i]   = randDivisor();
                end
            end
            if (pend == 2'b00) begin
                pend[0] = 1'b1;
                pa[0]   = $urandom();
                pb[0]   = randDivisor();
            end
            win  = (pend == 2'b11) ? pref : pend[1];
            pref = ~win;
            ea   = pa[win];
            eb   = pb[win];
            keep = pend;
            keep[win] = 1'b0;
            runAndCheck($sformatf("rand%0d", t), pend, keep, pa[0], pb[0], pa[1], pb[1], win,
                        (eb == 0) ? 32'hFFFFFFFF : ea / eb, (eb == 0) ? ea : ea % eb,
                        (eb == 0), 1'b0, int'($urandom_range(0, 3)), acc);
            pend[win] = 1'b0;
        end
        applyStimulus(2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL global_timeout: bench still running at %0t, required completion earlier", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
